// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 2*WIDTH-bit words from instruction memory, decodes
// opcode/argument and issues game commands (spawn/move/rotate/drop) to the engine.
// Ports: clk/rst (async active-low), start/stop/tick control, curr_command/out_data
// memory side, cmd_valid/cmd_ready/cmd_op/cmd_arg engine side, busy/halted/error status.
// Latency: 3 cycles per command instruction with ready high, 2 per JUMP; valid holds until accepted.
module instr_sequencer #(
  parameter int WIDTH               = 8,
  parameter int INSTRACTION_NUMBERS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               tick,
  output logic [WIDTH-1:0]   curr_command,
  input  logic [2*WIDTH-1:0] out_data,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [2:0]         cmd_op,
  output logic [WIDTH-1:0]   cmd_arg,
  output logic               busy,
  output logic               halted,
  output logic               error
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_ISSUE, S_WAIT, S_HALTED
  } state_t;

  localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(INSTRACTION_NUMBERS - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] OP_SPAWN  = WIDTH'(0);
  localparam logic [WIDTH-1:0] OP_LEFT   = WIDTH'(1);
  localparam logic [WIDTH-1:0] OP_RIGHT  = WIDTH'(2);
  localparam logic [WIDTH-1:0] OP_ROT    = WIDTH'(3);
  localparam logic [WIDTH-1:0] OP_DROP   = WIDTH'(4);
  localparam logic [WIDTH-1:0] OP_WAIT   = WIDTH'(5);
  localparam logic [WIDTH-1:0] OP_JUMP   = WIDTH'(6);
  localparam logic [WIDTH-1:0] OP_HALT   = WIDTH'(7);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [2:0]       cmd_op_q, cmd_op_d;
  logic [WIDTH-1:0] cmd_arg_q, cmd_arg_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] pc_next;

  // Sequential advance wraps at the end of instruction memory.
  assign pc_next = (pc_q == LAST_ADDR) ? '0 : pc_q + ONE;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    op_d        = op_q;
    arg_d       = arg_q;
    cnt_d       = cnt_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_arg_d   = cmd_arg_q;
    error_d     = error_q;

    if (stop) begin
      // stop beats start and a same-cycle handshake; pc and error survive.
      state_d     = S_IDLE;
      cmd_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_d    = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          // Single sample: a spawn word's figure id keeps changing while addressed.
          op_d    = out_data[2*WIDTH-1:WIDTH];
          arg_d   = out_data[WIDTH-1:0];
          state_d = S_EXEC;
        end
        S_EXEC: begin
          case (op_q)
            OP_SPAWN: begin
              cmd_op_d    = 3'd0;
              cmd_arg_d   = arg_q;
              cnt_d       = ONE;
              cmd_valid_d = 1'b1;
              state_d     = S_ISSUE;
            end
            OP_LEFT, OP_RIGHT, OP_ROT, OP_DROP: begin
              cmd_op_d    = op_q[2:0];
              cmd_arg_d   = '0;
              cnt_d       = (arg_q == '0) ? ONE : arg_q;
              cmd_valid_d = 1'b1;
              state_d     = S_ISSUE;
            end
            OP_WAIT: begin
              if (arg_q == '0) begin
                pc_d    = pc_next;
                state_d = S_FETCH;
              end else begin
                cnt_d   = arg_q;
                state_d = S_WAIT;
              end
            end
            OP_JUMP: begin
              if (arg_q <= LAST_ADDR) begin
                pc_d    = arg_q;
                state_d = S_FETCH;
              end else begin
                error_d = 1'b1;
                state_d = S_HALTED;
              end
            end
            OP_HALT: state_d = S_HALTED;
            default: begin
              error_d = 1'b1;
              state_d = S_HALTED;
            end
          endcase
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            if (cnt_q == ONE) begin
              cmd_valid_d = 1'b0;
              pc_d        = pc_next;
              state_d     = S_FETCH;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
        S_WAIT: begin
          if (tick) begin
            if (cnt_q == ONE) begin
              pc_d    = pc_next;
              state_d = S_FETCH;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
        S_HALTED: begin
          if (start) begin
            error_d = 1'b0;
            pc_d    = '0;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Status flags are registered from the next state so they line up with it.
    busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC) ||
               (state_d == S_ISSUE) || (state_d == S_WAIT);
    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      op_q        <= '0;
      arg_q       <= '0;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= 3'd0;
      cmd_arg_q   <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      op_q        <= op_d;
      arg_q       <= arg_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_arg_q   <= cmd_arg_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      error_q     <= error_d;
    end
  end

  assign curr_command = pc_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_op       = cmd_op_q;
  assign cmd_arg      = cmd_arg_q;
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign error        = error_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Consumer side of the instruction memory interface. Drives `curr_command` (the instruction address) and reads back the 2*WIDTH-bit word on `out_data`.
- Decodes each word as opcode = upper WIDTH bits and argument = lower WIDTH bits, then issues game commands (spawn/move/rotate/drop) to the game engine over a valid/ready handshake.
- Also handles tick-based waits, jumps and halt, and sits between the instruction memory and the playfield engine.
- A spawn word arrives with its argument already replaced by a random figure id (0..2). The sequencer forwards that argument unchanged.

Parameters:
- WIDTH, 8, opcode/argument/address width; instruction word is 2*WIDTH.
- INSTRACTION_NUMBERS, 4, number of instruction memory entries; valid addresses are 0..INSTRACTION_NUMBERS-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  sync pulse; begins or restarts execution at address 0 from IDLE or HALTED.
- stop  in  1  sync; forces IDLE next cycle from any state.
- tick  in  1  one-cycle game tick pulse, used by WAIT.
- curr_command  out  WIDTH  instruction address (registered PC).
- out_data  in  2*WIDTH  instruction word, combinational from memory at curr_command.
- cmd_valid  out  1  command offered to engine.
- cmd_ready  in  1  engine accepts command.
- cmd_op  out  3  command code: 0 spawn, 1 left, 2 right, 3 rotate, 4 drop.
- cmd_arg  out  WIDTH  command argument (figure id for spawn, else 0).
- busy  out  1  high in FETCH/EXEC/ISSUE/WAIT.
- halted  out  1  high in HALTED.
- error  out  1  sticky illegal-opcode / bad-jump flag.

Behaviour:
- Reset (rst=0, async): state IDLE, pc=0, curr_command=0, cmd_valid=0, cmd_op=0, cmd_arg=0, busy=0, halted=0, error=0, cnt=0.
- curr_command is always equal to pc, registered.
- States: IDLE, FETCH, EXEC, ISSUE, WAIT, HALTED.
- IDLE: start -> pc=0, FETCH.
- FETCH (1 cycle): the address settles. At the clock edge the sequencer latches op_r=out_data[2W-1:W] and arg_r=out_data[W-1:0], then goes to EXEC. out_data is sampled exactly once per fetch; the random figure advances while a spawn entry is addressed, so later cycles' values are ignored.
- EXEC (1 cycle) decodes op_r:
  - 0 SPAWN: cmd_op=0, cmd_arg=arg_r, cnt=1 -> ISSUE.
  - 1..4 LEFT/RIGHT/ROTATE/DROP: cmd_op=op_r, cmd_arg=0, cnt=(arg_r==0)?1:arg_r -> ISSUE.
  - 5 WAIT: if arg_r==0, advance immediately; else cnt=arg_r -> WAIT.
  - 6 JUMP: if arg_r<INSTRACTION_NUMBERS, pc=arg_r -> FETCH; else error=1 -> HALTED.
  - 7 HALT -> HALTED.
  - Any other opcode: error=1 -> HALTED.
  - cmd_valid is set at the EXEC edge, so it is first visible in the first ISSUE cycle.
- ISSUE: cmd_valid=1; cmd_op/cmd_arg held stable until handshake.
  - On cmd_valid&cmd_ready: if cnt==1, cmd_valid=0, advance pc, go to FETCH; else cnt-=1 and cmd_valid stays high (back-to-back accepts allowed).
  - valid is never dropped without a handshake, except on stop or reset.
- WAIT: each tick decrements cnt. When the tick finds cnt==1, advance pc and go to FETCH. tick in any other state is ignored.
- Advance: pc = (pc==INSTRACTION_NUMBERS-1) ? 0 : pc+1 (wrap-around).
- HALTED: halted=1, pc frozen. start clears error, sets pc=0, goes to FETCH.
- stop: next state IDLE, cmd_valid=0, cnt=0; pc and error are kept. stop has priority over start and over a same-cycle handshake (that command still counts as accepted by the engine).
- start while busy is ignored.
- Minimum cost: 3 cycles per command instruction with ready tied high; 2 cycles per JUMP.

Test Plan:
- Memory {0x0001, 0x0302, 0x0700, x}, ready=1, pulse start -> exactly 3 accepted commands: (0,1), (3,0), (3,0). halted=1 after HALT; curr_command stays 2.
- Spawn word 0x0002 with ready low 5 cycles -> cmd_valid high and cmd_arg=2 stable all 5 cycles; one handshake; next fetch at address 1.
- Memory {0x0503, 0x0100, 0x0600, x}, tick every 4 cycles -> WAIT consumes 3 ticks, then LEFT issued; JUMP returns to 0 and the loop repeats; curr_command only ever shows 0, 1, 2.
- Opcode 0x09 at address 1 -> error=1, halted=1, no cmd_valid. Then start -> error=0, fetch from 0.
- INSTRACTION_NUMBERS=4, program of four LEFT words -> pc wraps 3 -> 0. Also JUMP 0x0004 -> error=1, halted.
- Assert rst low mid-ISSUE with cmd_valid=1 -> all outputs return to reset values immediately (async); after release, idle until start. stop mid-WAIT -> IDLE; next start refetches from 0.
